metadata_packer: RTL and testbench
==================================

// Module: metadata_packer
// PURPOSE
//   Multi-channel successor to the single-image metadata emitter. On flush, snapshots per-channel
//   signature, corner count and ROI sum plus a 64-bit timestamp, then streams them as one framed
//   32-bit packet (header, payload, optional CRC) toward the PCIe DMA path with ready/valid
//   backpressure. All inputs are already synchronized to c; no CDC inside.
// PARAMETERS
//   NCH   2   image channels, legal 1..8
//   FCW   16  frame counter width, legal 1..16
// PORTS
//   c               in   1        clock
//   rst_n           in   1        asynchronous, active-low reset
//   en              in   1        arm block (IDLE -> CALC)
//   flush           in   1        end of frame; start packet emission (honoured in CALC only)
//   sig             in   NCH*32   per-channel image signature, channel k at [32k+31:32k]
//   corner_cnt      in   NCH*32   per-channel corner count
//   roi_sum         in   NCH*32   per-channel ROI pixel sum
//   t               in   64       timestamp
//   q_rdy           in   1        downstream ready
//   q               out  32       packet word
//   qv              out  1        q valid
//   flush_complete  out  1        1-cycle pulse after last word accepted
//   busy            out  1        high in HDR/EMIT/CRC/DONE
// BEHAVIOUR
//   - Reset: state=IDLE, q=0, qv=0, flush_complete=0, busy=0, frame counter=0, snapshot regs=0.
//   - Only one clock domain; async assert, synchronous deassert assumed by top-level reset sync.
//   - States: IDLE -en-> CALC; CALC -flush-> HDR; CALC -!en-> IDLE (flush wins if both same cycle);
//     HDR -accept-> EMIT; EMIT -last payload accept-> CRC (macro on) or DONE; CRC -accept-> DONE;
//     DONE -> IDLE unconditionally after one cycle.
//   - Snapshot: edge on which flush is sampled in CALC captures sig/corner_cnt/roi_sum/t;
//     inputs ignored afterwards until next frame.
//   - Packet word order: header; for k=0..NCH-1: sig[k], corner_cnt[k], roi_sum[k]; t[31:0];
//     t[63:32]; [crc].
//   - Header = {8'hA5, 8'(NWORDS), 16'(frame_cnt)}, NWORDS = total words incl. header
//     = 3*NCH+3 (+1 with CRC). frame_cnt zero-extended to 16 bits.
//   - Latency: qv rises the cycle after flush is sampled (header on q).
//   - Handshake: word accepted on any cycle with qv&&q_rdy. q and qv held stable while
//     qv&&!q_rdy. Next word presented the cycle after acceptance (zero bubble: q_rdy held
//     high gives one word per cycle). q is registered; qv never depends combinationally on q_rdy.
//   - Word index counter 5 bits, resets to 0 in HDR; last payload index = 3*NCH+1.
//   - DONE: qv=0, flush_complete=1 for exactly one cycle, frame_cnt increments, wrapping
//     2^FCW-1 -> 0.
//   - flush or en during HDR/EMIT/CRC/DONE ignored; en low mid-packet does not abort.
//   - rst_n low mid-packet: immediate abort, all outputs to reset values, frame_cnt cleared,
//     no flush_complete pulse.
//   - q holds last value (not zeroed) when qv=0 outside reset.
// CONFIGURATION
//   METADATA_CRC_EN defined: CRC-32 (poly 0x04C11DB7, reflected, init 0xFFFFFFFF, final xor
//     0xFFFFFFFF) over every accepted word from header through t[63:32], updated on acceptance;
//     emitted as final word; NWORDS includes it.
//   Not defined: no CRC logic or state; packet ends after t[63:32].
// TESTING
//   1 NCH=2, no CRC, q_rdy=1, flush in CALC -> 9 words back-to-back, header 32'hA5090000,
//     flush_complete pulses 1 cycle after word 9.
//   2 Second and 65537th frame -> header low 16 bits 16'h0001, then wrap to 16'h0000 (FCW=16).
//   3 q_rdy toggling 1-0-0-1 random -> no word dropped/duplicated, q stable while stalled,
//     order matches snapshot.
//   4 Inputs changed after flush sample -> packet carries pre-change values; flush while
//     IDLE or in EMIT -> no effect.
//   5 rst_n low during word 4 -> qv=0, busy=0 same cycle, no flush_complete, next frame
//     header count 0.
//   6 METADATA_CRC_EN, NCH=1, all payload 0 -> NWORDS=7, final word equals software CRC-32
//     model over the 6 prior words.

Source files
------------

// File: rtl/metadata_packer.sv
// Snapshots per-channel image metadata on flush and streams it as one framed packet.
// Optional trailing CRC-32 word when METADATA_CRC_EN is defined.
module metadata_packer #(
    parameter int NCH = 2,
    parameter int FCW = 16
) (
    input  logic              c,
    input  logic              rst_n,
    input  logic              en,
    input  logic              flush,
    input  logic [NCH*32-1:0] sig,
    input  logic [NCH*32-1:0] corner_cnt,
    input  logic [NCH*32-1:0] roi_sum,
    input  logic [63:0]       t,
    input  logic              q_rdy,
    output logic [31:0]       q,
    output logic              qv,
    output logic              flush_complete,
    output logic              busy
);

    localparam int NPAY = 3 * NCH + 2;
    localparam int LAST = NPAY - 1;
`ifdef METADATA_CRC_EN
    localparam int NWORDS = NPAY + 2;
`else
    localparam int NWORDS = NPAY + 1;
`endif

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CALC = 3'd1,
        S_HDR  = 3'd2,
        S_EMIT = 3'd3,
`ifdef METADATA_CRC_EN
        S_CRC  = 3'd4,
`endif
        S_DONE = 3'd5
    } state_t;

    state_t               state;
    state_t               state_nx;
    logic [4:0]           idx;
    logic [4:0]           sel;
    logic [FCW-1:0]       fcnt;
    logic [NPAY-1:0][31:0] snap;
    logic [NPAY-1:0][31:0] snap_d;
    logic [31:0]          pay_word;
    logic [31:0]          hdr;
    logic                 acc;
    logic                 last;

`ifdef METADATA_CRC_EN
    logic [31:0] crc;
    logic [31:0] crc_nx;

    // Reflected CRC-32, word consumed LSB first.
    function automatic logic [31:0] crc_word(input logic [31:0] cin, input logic [31:0] d);
        logic [31:0] r;
        r = cin;
        for (int i = 0; i < 32; i++)
            r = (r >> 1) ^ ((r[0] ^ d[i]) ? 32'hEDB88320 : 32'h0);
        return r;
    endfunction

    assign crc_nx = crc_word(crc, q);
`endif

    assign acc  = qv && q_rdy;
    assign last = (idx == 5'(LAST));
    assign hdr  = {8'hA5, 8'(NWORDS), 16'(fcnt)};

    always_comb begin
        snap_d = '0;
        for (int k = 0; k < NCH; k++) begin
            snap_d[3*k]   = sig[32*k +: 32];
            snap_d[3*k+1] = corner_cnt[32*k +: 32];
            snap_d[3*k+2] = roi_sum[32*k +: 32];
        end
        snap_d[3*NCH]   = t[31:0];
        snap_d[3*NCH+1] = t[63:32];
    end

    always_comb begin
        sel      = (state == S_HDR) ? idx : idx + 5'd1;
        pay_word = '0;
        for (int i = 0; i < NPAY; i++)
            if (sel == 5'(i)) pay_word = snap[i];
    end

    always_ff @(posedge c or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: if (en) state_nx = S_CALC;
            S_CALC: begin
                if (flush)    state_nx = S_HDR;
                else if (!en) state_nx = S_IDLE;
            end
            S_HDR:  if (acc) state_nx = S_EMIT;
`ifdef METADATA_CRC_EN
            S_EMIT: if (acc && last) state_nx = S_CRC;
            S_CRC:  if (acc) state_nx = S_DONE;
`else
            S_EMIT: if (acc && last) state_nx = S_DONE;
`endif
            S_DONE: state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        qv = (state == S_HDR) || (state == S_EMIT);
`ifdef METADATA_CRC_EN
        qv = qv || (state == S_CRC);
`endif
        flush_complete = (state == S_DONE);
        busy           = qv || flush_complete;
    end

    always_ff @(posedge c or negedge rst_n) begin
        if (!rst_n) begin
            q    <= '0;
            idx  <= '0;
            fcnt <= '0;
            snap <= '0;
`ifdef METADATA_CRC_EN
            crc  <= 32'hFFFFFFFF;
`endif
        end else begin
            if (state == S_CALC && flush) begin
                snap <= snap_d;
                q    <= hdr;
                idx  <= '0;
`ifdef METADATA_CRC_EN
                crc  <= 32'hFFFFFFFF;
`endif
            end
            if (acc && state == S_HDR) begin
                q <= pay_word;
`ifdef METADATA_CRC_EN
                crc <= crc_nx;
`endif
            end
            if (acc && state == S_EMIT) begin
`ifdef METADATA_CRC_EN
                crc <= crc_nx;
                if (last) q <= ~crc_nx;
`endif
                if (!last) begin
                    q   <= pay_word;
                    idx <= idx + 5'd1;
                end
            end
            if (state == S_DONE) fcnt <= fcnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_metadata_packer.sv
// Scoreboard bench for metadata_packer: expected words queued at flush,
// popped by a monitor as the DUT's words are accepted.
module tb_metadata_packer;

`ifdef METADATA_CRC_EN
    localparam int CW = 1;
`else
    localparam int CW = 0;
`endif
    localparam int NW  = 3 * 2 + 3 + CW;
    localparam int NW2 = 3 * 1 + 3 + CW;

    logic        c = 1'b0;
    logic        rst_n;
    logic        en, flush, q_rdy;
    logic [63:0] sig, corner_cnt, roi_sum;
    logic [63:0] t;
    logic [31:0] q;
    logic        qv, flush_complete, busy;

    logic        en2, flush2, rdy2;
    logic [31:0] q2;
    logic        qv2, fc2, busy2;

    int          n_chk = 0;
    int          n_err = 0;
    logic [31:0] sb[$];
    logic [15:0] mfc = 16'd0;
    logic        stall_prev = 1'b0;
    logic [31:0] q_prev = '0;

    always #5 c = ~c;

    metadata_packer #(.NCH(2), .FCW(16)) dut (
        .c(c), .rst_n(rst_n), .en(en), .flush(flush),
        .sig(sig), .corner_cnt(corner_cnt), .roi_sum(roi_sum), .t(t),
        .q_rdy(q_rdy), .q(q), .qv(qv),
        .flush_complete(flush_complete), .busy(busy)
    );

    metadata_packer #(.NCH(1), .FCW(2)) u_w (
        .c(c), .rst_n(rst_n), .en(en2), .flush(flush2),
        .sig(sig[31:0]), .corner_cnt(corner_cnt[31:0]),
        .roi_sum(roi_sum[31:0]), .t(t),
        .q_rdy(rdy2), .q(q2), .qv(qv2),
        .flush_complete(fc2), .busy(busy2)
    );

    function automatic logic [31:0] crc_step(input logic [31:0] r0, input logic [31:0] d);
        logic [31:0] r;
        r = r0;
        for (int i = 0; i < 32; i++)
            r = (r >> 1) ^ ((r[0] ^ d[i]) ? 32'hEDB88320 : 32'h0);
        return r;
    endfunction

    // Monitor: pops one expected word per accepted word, checks stall stability.
    always @(negedge c) begin
        logic [31:0] e;
        if (rst_n) begin
            if (stall_prev) begin
                n_chk++;
                if (qv !== 1'b1 || q !== q_prev) begin
                    n_err++;
                    $display("FAIL stall_hold: qv=%b q=%h required qv=1 q=%h", qv, q, q_prev);
                end
            end
            if (qv && q_rdy) begin
                n_chk++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL extra_word: got %h required no word", q);
                end else begin
                    e = sb.pop_front();
                    if (q !== e) begin
                        n_err++;
                        $display("FAIL word: got %h required %h", q, e);
                    end
                end
            end
            stall_prev = qv && !q_rdy;
            q_prev     = q;
        end else begin
            stall_prev = 1'b0;
        end
    end

    task automatic tick;
        @(posedge c);
        #1;
    endtask

    task automatic push_expected;
        logic [31:0] w[$];
        logic [31:0] crc;
        w.push_back({8'hA5, 8'(NW), mfc});
        for (int k = 0; k < 2; k++) begin
            w.push_back(sig[32*k +: 32]);
            w.push_back(corner_cnt[32*k +: 32]);
            w.push_back(roi_sum[32*k +: 32]);
        end
        w.push_back(t[31:0]);
        w.push_back(t[63:32]);
        crc = 32'hFFFFFFFF;
        foreach (w[i]) begin
            crc = crc_step(crc, w[i]);
            sb.push_back(w[i]);
        end
        if (CW == 1) sb.push_back(~crc);
    endtask

    task automatic randomize_inputs;
        sig        = {$urandom, $urandom};
        corner_cnt = {$urandom, $urandom};
        roi_sum    = {$urandom, $urandom};
        t          = {$urandom, $urandom};
    endtask

    // mode 0: ready held high, 1: random ready, 2: ready pattern 1-0-0-1
    task automatic run_frame(input int mode, input bit perturb);
        logic [3:0] pat;
        bit         done;
        bit         lst;
        int         ncyc;
        pat  = 4'b1001;
        done = 0;
        ncyc = 0;
        en   = 1'b1;
        repeat (2) tick;
        push_expected();
        flush = 1'b1;
        tick;
        flush = 1'b0;
        n_chk++;
        if (qv !== 1'b1 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL latency: qv=%b busy=%b required 1 1", qv, busy);
        end
        if (perturb) randomize_inputs();
        for (int i = 0; i < 300 && !done; i++) begin
            case (mode)
                0:       q_rdy = 1'b1;
                1:       q_rdy = 1'($urandom_range(0, 1));
                default: q_rdy = pat[i%4];
            endcase
            if (perturb) begin
                flush = (i == 2);
                if (i == 2) en = 1'b0;
            end
            lst = qv && q_rdy && (sb.size() == 1);
            tick;
            n_chk++;
            if (flush_complete !== lst) begin
                n_err++;
                $display("FAIL flush_complete: got %b required %b", flush_complete, lst);
            end
            if (lst) begin
                done = 1;
                ncyc = i + 1;
            end
        end
        flush = 1'b0;
        n_chk++;
        if (!done) begin
            n_err++;
            $display("FAIL timeout: %0d words left required 0", sb.size());
            sb.delete();
        end
        if (mode == 0) begin
            n_chk++;
            if (ncyc != NW) begin
                n_err++;
                $display("FAIL zero_bubble: %0d cycles required %0d", ncyc, NW);
            end
        end
        tick;
        n_chk++;
        if (flush_complete !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL pulse_end: fc=%b busy=%b required 0 0", flush_complete, busy);
        end
        mfc++;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; en = 0; flush = 0; q_rdy = 0;
        en2 = 0; flush2 = 0; rdy2 = 1;
        sig = 64'h1111_2222_3333_4444;
        corner_cnt = 64'h5555_6666_7777_8888;
        roi_sum = 64'h9999_AAAA_BBBB_CCCC;
        t = 64'hDEAD_BEEF_0123_4567;
        #12;
        n_chk++;
        if (q !== 32'h0 || qv !== 1'b0 || flush_complete !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset: q=%h qv=%b fc=%b busy=%b required 0 0 0 0",
                     q, qv, flush_complete, busy);
        end
        tick;
        rst_n = 1'b1;
        tick;
    endtask

    task automatic test_basic;
        run_frame(0, 0);
        randomize_inputs();
        run_frame(0, 0);
    endtask

    task automatic test_backpressure;
        randomize_inputs();
        run_frame(1, 0);
        randomize_inputs();
        run_frame(2, 0);
    endtask

    task automatic test_snapshot_and_ignore;
        randomize_inputs();
        run_frame(0, 1);
        en = 1'b0;
        repeat (3) tick;
        flush = 1'b1;
        tick;
        flush = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_chk++;
            if (qv !== 1'b0 || busy !== 1'b0) begin
                n_err++;
                $display("FAIL idle_flush: qv=%b busy=%b required 0 0", qv, busy);
            end
            tick;
        end
    endtask

    task automatic test_reset_abort;
        randomize_inputs();
        en = 1'b1;
        q_rdy = 1'b1;
        repeat (2) tick;
        push_expected();
        flush = 1'b1;
        tick;
        flush = 1'b0;
        repeat (3) tick;
        rst_n = 1'b0;
        #1;
        n_chk++;
        if (qv !== 1'b0 || busy !== 1'b0 || q !== 32'h0 || flush_complete !== 1'b0) begin
            n_err++;
            $display("FAIL abort: qv=%b busy=%b q=%h fc=%b required 0 0 0 0",
                     qv, busy, q, flush_complete);
        end
        sb.delete();
        repeat (2) begin
            tick;
            n_chk++;
            if (flush_complete !== 1'b0) begin
                n_err++;
                $display("FAIL abort_pulse: fc=%b required 0", flush_complete);
            end
        end
        rst_n = 1'b1;
        mfc = 16'd0;
        randomize_inputs();
        run_frame(0, 0);
    endtask

    task automatic test_wrap;
        bit seen;
        en2 = 1'b1;
        repeat (2) tick;
        for (int f = 0; f < 6; f++) begin
            flush2 = 1'b1;
            tick;
            flush2 = 1'b0;
            n_chk++;
            if (qv2 !== 1'b1 || q2 !== {8'hA5, 8'(NW2), 16'(f % 4)}) begin
                n_err++;
                $display("FAIL wrap_hdr: qv=%b q=%h required 1 %h",
                         qv2, q2, {8'hA5, 8'(NW2), 16'(f % 4)});
            end
            seen = 0;
            for (int i = 0; i < 20 && !seen; i++) begin
                tick;
                seen = fc2;
            end
            n_chk++;
            if (!seen) begin
                n_err++;
                $display("FAIL wrap_timeout: fc=%b required 1", fc2);
            end
            repeat (2) tick;
        end
        en2 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_snapshot_and_ignore();
        test_reset_abort();
        test_wrap();
        repeat (2) tick;
        n_chk++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL leftover: %0d words required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
